// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter. A grant is held for a whole CYC.
// A bus cycle that stalls too long is ended with a one-cycle ERR to the granted master.
module wb_master_arbiter #(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      gnt_o
);

  // State encoding doubles as the one-hot grant vector.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;

  // Timer is 8 bits wide, so only the low byte of TIMEOUT is meaningful.
  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] timer_q, timer_d;
  logic       err_q, err_d;
  logic [1:0] gnt;
  logic       granted_cyc;
  logic       stall;

  // Grant is suppressed while reset is asserted so the bus drops immediately.
  assign gnt   = rst_i ? IDLE : state_q;
  assign gnt_o = gnt;

  // Read data is broadcast; only ack/err are steered.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Ack is withheld in the err cycle so a late slave ack cannot complete the cycle.
  assign m0_ack_o = gnt[0] & s_ack_i & ~err_q;
  assign m1_ack_o = gnt[1] & s_ack_i & ~err_q;
  assign m0_err_o = gnt[0] & err_q;
  assign m1_err_o = gnt[1] & err_q;

  // Bus mux: forward the granted master; cyc/stb forced low during the err cycle.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    case (gnt)
      GNT0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_cyc_o = m0_cyc_i & ~err_q;
        s_stb_o = m0_stb_i & ~err_q;
      end
      GNT1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i & ~err_q;
        s_stb_o = m1_stb_i & ~err_q;
      end
      default: ;
    endcase
  end

  assign granted_cyc = (state_q == GNT1) ? m1_cyc_i : m0_cyc_i;
  assign stall       = s_cyc_o & s_stb_o & ~s_ack_i;

  // Arbitration, release and stall timeout. Timer counts completed stall cycles;
  // the TIMEOUT-th stall cycle arms err for the following cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    timer_d = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (!granted_cyc) begin
          state_d = IDLE;
          last_d  = (state_q == GNT1);
        end else if (stall) begin
          if ((TIMEOUT_VAL != 8'd0) && (timer_q == TIMEOUT_VAL - 8'd1)) begin
            err_d = 1'b1;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; m0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: arbitration order, release gap, timeout, reset.
module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr, m1_adr;
  logic [15:0] m0_dat, m1_dat;
  logic [1:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic [15:0] s_dat_in;
  logic        s_ack;

  logic [15:0] m0_rdat, m1_rdat, z_m0_rdat, z_m1_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err;
  logic [31:0] s_adr, z_s_adr;
  logic [15:0] s_wdat, z_s_wdat;
  logic [1:0]  s_sel, z_s_sel, gnt, z_gnt;
  logic        s_we, s_cyc, s_stb, z_s_we, z_s_cyc, z_s_stb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(.DW(16), .AW(32), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
    .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
    .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we), .s_cyc_o(s_cyc),
    .s_stb_o(s_stb), .s_dat_i(s_dat_in), .s_ack_i(s_ack), .gnt_o(gnt)
  );

  // Same stimulus with the timeout disabled.
  wb_master_arbiter #(.DW(16), .AW(32), .TIMEOUT(0)) dut_nto (
    .clk_i(clk), .rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(z_m0_rdat), .m0_ack_o(z_m0_ack),
    .m0_err_o(z_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(z_m1_rdat), .m1_ack_o(z_m1_ack),
    .m1_err_o(z_m1_err),
    .s_adr_o(z_s_adr), .s_dat_o(z_s_wdat), .s_sel_o(z_s_sel), .s_we_o(z_s_we),
    .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_dat_i(s_dat_in), .s_ack_i(s_ack),
    .gnt_o(z_gnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_adr = '0; m0_dat = 16'h0; m0_sel = 2'b11; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_adr = '0; m1_dat = 16'h0; m1_sel = 2'b11; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    s_dat_in = '0; s_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_gnt;

    // Reset state
    do_reset();
    #1;
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_cyc", 32'(s_cyc), 32'h0);
    check_eq("rst_adr", s_adr, 32'h0);

    // 1: m0 read, slave acks two cycles after stb
    m0_adr = 32'h1000; m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0;
    #1;
    check_eq("t1_req_cyc", 32'(s_cyc), 32'h0);
    step(); #1;
    check_eq("t1_gnt", 32'(gnt), 32'h1);
    check_eq("t1_cyc", 32'(s_cyc), 32'h1);
    check_eq("t1_adr", s_adr, 32'h1000);
    check_eq("t1_stall_ack", 32'(m0_ack), 32'h0);
    step(); #1;
    check_eq("t1_stall2_ack", 32'(m0_ack), 32'h0);
    step();
    s_ack = 1'b1; s_dat_in = 16'hBEEF;
    #1;
    check_eq("t1_ack", 32'(m0_ack), 32'h1);
    check_eq("t1_dat", 32'(m0_rdat), 32'hBEEF);
    check_eq("t1_m1_ack", 32'(m1_ack), 32'h0);
    step();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    check_eq("t1_rel_cyc", 32'(s_cyc), 32'h0);
    step(); #1;
    check_eq("t1_idle_gnt", 32'(gnt), 32'h0);

    // 2: simultaneous request after reset, m0 first, one idle cycle, then m1
    do_reset();
    m0_adr = 32'h1111; m1_adr = 32'h2000;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step(); #1;
    check_eq("t2_gnt0", 32'(gnt), 32'h1);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step(); #1;
    check_eq("t2_gap", 32'(gnt), 32'h0);
    step(); #1;
    check_eq("t2_gnt1", 32'(gnt), 32'h2);
    check_eq("t2_adr", s_adr, 32'h2000);

    // 3: both re-request immediately after release -> 0,1,0,1,0,1
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
      s_ack = 1'b1;
      #1;
      check_eq($sformatf("t3_gnt%0d", i), 32'(gnt), 32'(exp_gnt));
      check_eq($sformatf("t3_ack%0d", i), 32'({m1_ack, m0_ack}), 32'(exp_gnt));
      step();
      s_ack = 1'b0;
      if (exp_gnt[0]) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      else begin m1_cyc = 1'b0; m1_stb = 1'b0; end
      step();
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    end

    // 4: m1 write never acked; TIMEOUT=4 errs once, TIMEOUT=0 never
    do_reset();
    m1_adr = 32'h5000; m1_we = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1; m1_dat = 16'h1234;
    step(); #1;
    check_eq("t4_gnt", 32'(gnt), 32'h2);
    check_eq("t4_wdat", 32'(s_wdat), 32'h1234);
    for (int i = 1; i <= 4; i++) begin
      check_eq($sformatf("t4_noerr%0d", i), 32'(m1_err), 32'h0);
      check_eq($sformatf("t4_nto_noerr%0d", i), 32'(z_m1_err), 32'h0);
      step(); #1;
    end
    check_eq("t4_err", 32'(m1_err), 32'h1);
    check_eq("t4_err_stb", 32'(s_stb), 32'h0);
    check_eq("t4_err_cyc", 32'(s_cyc), 32'h0);
    check_eq("t4_m0_ackerr", 32'({m0_ack, m0_err}), 32'h0);
    check_eq("t4_nto_err", 32'(z_m1_err), 32'h0);
    check_eq("t4_nto_stb", 32'(z_s_stb), 32'h1);
    s_ack = 1'b1;
    #1;
    check_eq("t4_ack_ignored", 32'(m1_ack), 32'h0);
    step();
    s_ack = 1'b0;
    #1;
    check_eq("t4_err_pulse", 32'(m1_err), 32'h0);
    check_eq("t4_stb_back", 32'(s_stb), 32'h1);
    check_eq("t4_gnt_held", 32'(gnt), 32'h2);
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    step();
    step();

    // 5: reset during GNT1 stall, then simultaneous request -> m0
    do_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    step(); #1;
    check_eq("t5_gnt1", 32'(gnt), 32'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_eq("t5_gnt", 32'(gnt), 32'h0);
    check_eq("t5_cyc", 32'(s_cyc), 32'h0);
    check_eq("t5_errs", 32'({m1_err, m0_err}), 32'h0);
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step(); #1;
    check_eq("t5_m0_wins", 32'(gnt), 32'h1);

    // 6: m1 requests while m0 holds the bus with ack pending
    do_reset();
    m0_adr = 32'h3000; m0_cyc = 1'b1; m0_stb = 1'b1;
    step(); #1;
    check_eq("t6_gnt0", 32'(gnt), 32'h1);
    m1_adr = 32'h4000; m1_cyc = 1'b1; m1_stb = 1'b1;
    #1;
    check_eq("t6_adr_a", s_adr, 32'h3000);
    step(); #1;
    check_eq("t6_m1_ackerr", 32'({m1_ack, m1_err}), 32'h0);
    check_eq("t6_adr_b", s_adr, 32'h3000);
    check_eq("t6_gnt_held", 32'(gnt), 32'h1);
    step();
    s_ack = 1'b1;
    #1;
    check_eq("t6_m0_ack", 32'(m0_ack), 32'h1);
    check_eq("t6_m1_noack", 32'(m1_ack), 32'h0);
    step();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step(); #1;
    check_eq("t6_gap", 32'(gnt), 32'h0);
    check_eq("t6_idle_adr", s_adr, 32'h0);
    step(); #1;
    check_eq("t6_gnt1", 32'(gnt), 32'h2);
    check_eq("t6_adr_m1", s_adr, 32'h4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
